// File: rtl/seq_detect_if.sv
// Handshake bundle between a host/config master and the serial pattern detector.
// The host drives config, run commands and serial bits; the detector returns status and matches.
interface seq_detect_if #(
  parameter int PAT_W = 4,
  parameter int LEN_W = 3,
  parameter int CNT_W = 8
);
  logic             cfg_valid;
  logic             cfg_ready;
  logic [PAT_W-1:0] cfg_pattern;
  logic [LEN_W-1:0] cfg_len;
  logic             cfg_overlap;
  logic [CNT_W-1:0] cfg_limit;
  logic             start;
  logic             abort;
  logic             din_valid;
  logic             din;
  logic             din_ready;
  logic             match;
  logic [CNT_W-1:0] match_cnt;
  logic             busy;
  logic             done;

  modport master (
    output cfg_valid, cfg_pattern, cfg_len, cfg_overlap, cfg_limit,
    output start, abort, din_valid, din,
    input  cfg_ready, din_ready, match, match_cnt, busy, done
  );

  modport slave (
    input  cfg_valid, cfg_pattern, cfg_len, cfg_overlap, cfg_limit,
    input  start, abort, din_valid, din,
    output cfg_ready, din_ready, match, match_cnt, busy, done
  );
endinterface

// File: rtl/seq_detect_ctrl.sv
// Configurable serial bit-pattern detector with run control, match counting and a match limit.
// IDLE/DONE accept configuration; RUN consumes gated serial bits and pulses match one clock later.
module seq_detect_ctrl #(
  parameter int PAT_W = 4,
  parameter int LEN_W = 3,
  parameter int CNT_W = 8
) (
  input  logic         clk,
  input  logic         clr,
  seq_detect_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_nxt_s;

  logic [PAT_W-1:0] cfg_pattern_r;
  logic [LEN_W-1:0] cfg_len_r;
  logic             cfg_overlap_r;
  logic [CNT_W-1:0] cfg_limit_r;
  logic             cfg_loaded_r;

  logic [PAT_W-1:0] shreg_r;
  logic [PAT_W-1:0] shreg_nxt_s;
  logic [PAT_W-1:0] shreg_shift_s;
  logic [LEN_W-1:0] hist_r;
  logic [LEN_W-1:0] hist_nxt_s;
  logic [LEN_W-1:0] hist_inc_s;
  logic [CNT_W-1:0] match_cnt_r;
  logic [CNT_W-1:0] cnt_nxt_s;
  logic [CNT_W-1:0] cnt_inc_s;
  logic             match_r;
  logic             match_nxt_s;
  logic             busy_r;
  logic             done_r;
  logic             din_ready_r;

  logic             cfg_ready_s;
  logic             cfg_fire_s;
  logic             din_fire_s;
  logic             start_ok_s;
  logic             hit_s;
  logic             limit_hit_s;

  // Zero length is meaningless and lengths beyond the shift register cannot be observed.
  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
    logic [LEN_W-1:0] res;
    if (len == {LEN_W{1'b0}}) begin
      res = LEN_W'(1'b1);
    end else if (len > LEN_W'(PAT_W)) begin
      res = LEN_W'(PAT_W);
    end else begin
      res = len;
    end
    return res;
  endfunction

  function automatic logic [PAT_W-1:0] len_mask(input logic [LEN_W-1:0] len);
    logic [PAT_W-1:0] m;
    for (int i = 0; i < PAT_W; i++) begin
      m[i] = (LEN_W'(i) < len);
    end
    return m;
  endfunction

  function automatic logic pattern_hit(
    input logic [PAT_W-1:0] shreg,
    input logic [PAT_W-1:0] pattern,
    input logic [LEN_W-1:0] len,
    input logic [LEN_W-1:0] hist
  );
    return (hist >= len) &&
           (((shreg ^ pattern) & len_mask(len)) == {PAT_W{1'b0}});
  endfunction

  assign cfg_ready_s   = (state_r == ST_IDLE) || (state_r == ST_DONE);
  assign cfg_fire_s    = bus.cfg_valid & cfg_ready_s;
  assign din_fire_s    = bus.din_valid & din_ready_r;
  // A config handshake in the same cycle as start counts as loaded for that start.
  assign start_ok_s    = bus.start & (cfg_loaded_r | cfg_fire_s);

  assign shreg_shift_s = {shreg_r[PAT_W-2:0], bus.din};
  assign hist_inc_s    = (hist_r >= LEN_W'(PAT_W)) ? hist_r : (hist_r + LEN_W'(1'b1));
  assign cnt_inc_s     = (&match_cnt_r) ? match_cnt_r : (match_cnt_r + CNT_W'(1'b1));
  assign hit_s         = pattern_hit(shreg_shift_s, cfg_pattern_r, cfg_len_r, hist_inc_s);
  assign limit_hit_s   = (cfg_limit_r != {CNT_W{1'b0}}) && (cnt_inc_s == cfg_limit_r);

  assign bus.cfg_ready = cfg_ready_s;
  assign bus.din_ready = din_ready_r;
  assign bus.match     = match_r;
  assign bus.match_cnt = match_cnt_r;
  assign bus.busy      = busy_r;
  assign bus.done      = done_r;

  // State register.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state and datapath next values; abort outranks both bit acceptance and the limit.
  always_comb begin
    state_nxt_s = state_r;
    shreg_nxt_s = shreg_r;
    hist_nxt_s  = hist_r;
    cnt_nxt_s   = match_cnt_r;
    match_nxt_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start_ok_s) begin
          state_nxt_s = ST_RUN;
          shreg_nxt_s = {PAT_W{1'b0}};
          hist_nxt_s  = {LEN_W{1'b0}};
          cnt_nxt_s   = {CNT_W{1'b0}};
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (bus.abort) begin
          state_nxt_s = ST_IDLE;
        end else if (din_fire_s) begin
          shreg_nxt_s = shreg_shift_s;
          hist_nxt_s  = hist_inc_s;
          if (hit_s) begin
            match_nxt_s = 1'b1;
            cnt_nxt_s   = cnt_inc_s;
            hist_nxt_s  = cfg_overlap_r ? hist_inc_s : {LEN_W{1'b0}};
            state_nxt_s = limit_hit_s ? ST_DONE : ST_RUN;
          end else begin
            state_nxt_s = ST_RUN;
          end
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_DONE: begin
        if (bus.abort) begin
          state_nxt_s = ST_IDLE;
        end else if (start_ok_s) begin
          state_nxt_s = ST_RUN;
          shreg_nxt_s = {PAT_W{1'b0}};
          hist_nxt_s  = {LEN_W{1'b0}};
          cnt_nxt_s   = {CNT_W{1'b0}};
        end else begin
          state_nxt_s = ST_DONE;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Configuration registers, written only on an accepted handshake.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      cfg_pattern_r <= {PAT_W{1'b0}};
      cfg_len_r     <= LEN_W'(1'b1);
      cfg_overlap_r <= 1'b0;
      cfg_limit_r   <= {CNT_W{1'b0}};
      cfg_loaded_r  <= 1'b0;
    end else if (cfg_fire_s) begin
      cfg_pattern_r <= bus.cfg_pattern;
      cfg_len_r     <= clamp_len(bus.cfg_len);
      cfg_overlap_r <= bus.cfg_overlap;
      cfg_limit_r   <= bus.cfg_limit;
      cfg_loaded_r  <= 1'b1;
    end
  end

  // Detector datapath and registered status outputs decoded from the next state.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      shreg_r     <= {PAT_W{1'b0}};
      hist_r      <= {LEN_W{1'b0}};
      match_cnt_r <= {CNT_W{1'b0}};
      match_r     <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      din_ready_r <= 1'b0;
    end else begin
      shreg_r     <= shreg_nxt_s;
      hist_r      <= hist_nxt_s;
      match_cnt_r <= cnt_nxt_s;
      match_r     <= match_nxt_s;
      busy_r      <= (state_nxt_s == ST_RUN);
      done_r      <= (state_nxt_s == ST_DONE);
      din_ready_r <= (state_nxt_s == ST_RUN);
    end
  end

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Directed bench for seq_detect_ctrl: expected match bits are queued per driven bit and
// checked one clock later; status outputs are checked against hand-derived constants.
module tb_seq_detect_ctrl;

  logic clk;
  logic clr;
  int   pass_cnt;
  int   total_cnt;
  logic sb[$];

  seq_detect_if #(.PAT_W(4), .LEN_W(3), .CNT_W(8)) bus ();

  seq_detect_ctrl #(.PAT_W(4), .LEN_W(3), .CNT_W(8)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic cfg_write(input logic [3:0] p, input logic [2:0] l, input logic ov,
                           input logic [7:0] lim, input logic with_start);
    chk("cfg_ready_before_cfg", {31'd0, bus.cfg_ready}, 32'd1);
    bus.cfg_valid   = 1'b1;
    bus.cfg_pattern = p;
    bus.cfg_len     = l;
    bus.cfg_overlap = ov;
    bus.cfg_limit   = lim;
    bus.start       = with_start;
    cyc();
    bus.cfg_valid   = 1'b0;
    bus.start       = 1'b0;
  endtask

  task automatic do_start();
    bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
  endtask

  task automatic do_abort();
    bus.abort = 1'b1;
    cyc();
    bus.abort = 1'b0;
  endtask

  task automatic send(input logic b, input logic exp);
    bus.din_valid = 1'b1;
    bus.din       = b;
    sb.push_back(exp);
    cyc();
    bus.din_valid = 1'b0;
    chk("match", {31'd0, bus.match}, {31'd0, sb.pop_front()});
  endtask

  task automatic idle_chk(input string tag);
    cyc();
    chk(tag, {31'd0, bus.match}, 32'd0);
  endtask

  initial begin
    pass_cnt        = 0;
    total_cnt       = 0;
    clr             = 1'b0;
    bus.cfg_valid   = 1'b0;
    bus.cfg_pattern = 4'd0;
    bus.cfg_len     = 3'd0;
    bus.cfg_overlap = 1'b0;
    bus.cfg_limit   = 8'd0;
    bus.start       = 1'b0;
    bus.abort       = 1'b0;
    bus.din_valid   = 1'b0;
    bus.din         = 1'b0;
    cyc();
    cyc();

    // Reset state
    chk("rst_cfg_ready", {31'd0, bus.cfg_ready}, 32'd1);
    chk("rst_din_ready", {31'd0, bus.din_ready}, 32'd0);
    chk("rst_busy",      {31'd0, bus.busy},      32'd0);
    chk("rst_done",      {31'd0, bus.done},      32'd0);
    chk("rst_match",     {31'd0, bus.match},     32'd0);
    chk("rst_match_cnt", {24'd0, bus.match_cnt}, 32'd0);
    clr = 1'b1;
    cyc();

    // start with no config loaded is ignored
    do_start();
    chk("nocfg_busy",      {31'd0, bus.busy},      32'd0);
    chk("nocfg_din_ready", {31'd0, bus.din_ready}, 32'd0);

    // Pattern 110, no overlap, unlimited
    cfg_write(4'b0110, 3'd3, 1'b0, 8'd0, 1'b0);
    do_start();
    chk("run_busy",      {31'd0, bus.busy},      32'd1);
    chk("run_din_ready", {31'd0, bus.din_ready}, 32'd1);
    chk("run_cfg_ready", {31'd0, bus.cfg_ready}, 32'd0);
    send(1'b1, 1'b0); send(1'b1, 1'b0); send(1'b0, 1'b1);
    send(1'b1, 1'b0); send(1'b1, 1'b0); send(1'b0, 1'b1);
    chk("p110_cnt",  {24'd0, bus.match_cnt}, 32'd2);
    chk("p110_busy", {31'd0, bus.busy},      32'd1);

    // Config offered during RUN is refused; old pattern keeps matching
    bus.cfg_valid   = 1'b1;
    bus.cfg_pattern = 4'b0001;
    bus.cfg_len     = 3'd3;
    chk("run_cfg_refused", {31'd0, bus.cfg_ready}, 32'd0);
    cyc();
    bus.cfg_valid = 1'b0;
    send(1'b1, 1'b0); send(1'b1, 1'b0); send(1'b0, 1'b1);
    chk("oldcfg_cnt", {24'd0, bus.match_cnt}, 32'd3);
    do_abort();
    chk("abort_busy",    {31'd0, bus.busy},      32'd0);
    chk("abort_cnthold", {24'd0, bus.match_cnt}, 32'd3);

    // Pattern 11 with overlap
    cfg_write(4'b0011, 3'd2, 1'b1, 8'd0, 1'b0);
    do_start();
    chk("restart_cnt_clr", {24'd0, bus.match_cnt}, 32'd0);
    send(1'b1, 1'b0); send(1'b1, 1'b1); send(1'b1, 1'b1); send(1'b1, 1'b1);
    chk("ovl1_cnt", {24'd0, bus.match_cnt}, 32'd3);
    do_abort();

    // Pattern 11 without overlap
    cfg_write(4'b0011, 3'd2, 1'b0, 8'd0, 1'b0);
    do_start();
    send(1'b1, 1'b0); send(1'b1, 1'b1); send(1'b1, 1'b0); send(1'b1, 1'b1);
    chk("ovl0_cnt", {24'd0, bus.match_cnt}, 32'd2);
    do_abort();

    // Limit of 2 matches on pattern 10
    cfg_write(4'b0010, 3'd2, 1'b0, 8'd2, 1'b0);
    do_start();
    send(1'b1, 1'b0); send(1'b0, 1'b1);
    chk("lim_not_done", {31'd0, bus.done}, 32'd0);
    send(1'b1, 1'b0); send(1'b0, 1'b1);
    chk("lim_done",      {31'd0, bus.done},      32'd1);
    chk("lim_din_ready", {31'd0, bus.din_ready}, 32'd0);
    chk("lim_busy",      {31'd0, bus.busy},      32'd0);
    send(1'b1, 1'b0); send(1'b0, 1'b0);
    chk("lim_cnt",       {24'd0, bus.match_cnt}, 32'd2);
    chk("lim_done_hold", {31'd0, bus.done},      32'd1);
    do_start();
    chk("done_restart_busy", {31'd0, bus.busy},      32'd1);
    chk("done_restart_done", {31'd0, bus.done},      32'd0);
    chk("done_restart_cnt",  {24'd0, bus.match_cnt}, 32'd0);
    do_abort();

    // abort wins over a limit-reaching match in the same cycle
    cfg_write(4'b0010, 3'd2, 1'b0, 8'd1, 1'b0);
    do_start();
    send(1'b1, 1'b0);
    bus.abort = 1'b1;
    send(1'b0, 1'b0);
    bus.abort = 1'b0;
    chk("abortprio_done", {31'd0, bus.done},      32'd0);
    chk("abortprio_busy", {31'd0, bus.busy},      32'd0);
    chk("abortprio_cnt",  {24'd0, bus.match_cnt}, 32'd0);

    // Gaps in din_valid are invisible to matching
    cfg_write(4'b0110, 3'd3, 1'b0, 8'd0, 1'b0);
    do_start();
    send(1'b1, 1'b0);
    for (int i = 0; i < 3; i++) idle_chk("gap_a");
    send(1'b1, 1'b0);
    for (int i = 0; i < 3; i++) idle_chk("gap_b");
    send(1'b0, 1'b1);
    idle_chk("gap_pulse_end");
    chk("gap_cnt", {24'd0, bus.match_cnt}, 32'd1);

    // Abort mid-pattern: the bit in the abort cycle would have completed 110
    send(1'b1, 1'b0); send(1'b1, 1'b0);
    bus.abort = 1'b1;
    send(1'b0, 1'b0);
    bus.abort = 1'b0;
    chk("abortmid_busy", {31'd0, bus.busy},      32'd0);
    chk("abortmid_cnt",  {24'd0, bus.match_cnt}, 32'd1);
    idle_chk("abortmid_nopulse");
    do_start();
    send(1'b0, 1'b0);
    chk("stray0_cnt", {24'd0, bus.match_cnt}, 32'd0);

    // Asynchronous reset mid-pattern
    send(1'b1, 1'b0); send(1'b1, 1'b0);
    clr = 1'b0;
    #1;
    chk("clr_busy",      {31'd0, bus.busy},      32'd0);
    chk("clr_match",     {31'd0, bus.match},     32'd0);
    chk("clr_cfg_ready", {31'd0, bus.cfg_ready}, 32'd1);
    chk("clr_din_ready", {31'd0, bus.din_ready}, 32'd0);
    cyc();
    clr = 1'b1;
    bus.din_valid = 1'b1;
    bus.din       = 1'b0;
    idle_chk("clr_nopulse");
    bus.din_valid = 1'b0;
    do_start();
    chk("clr_cfg_unloaded", {31'd0, bus.busy}, 32'd0);

    // Same-cycle config and start; cfg_len=0 stored as 1
    cfg_write(4'b0001, 3'd0, 1'b0, 8'd0, 1'b1);
    chk("cfgstart_busy", {31'd0, bus.busy}, 32'd1);
    send(1'b1, 1'b1); send(1'b0, 1'b0); send(1'b1, 1'b1);
    chk("len0_cnt", {24'd0, bus.match_cnt}, 32'd2);
    do_abort();

    // cfg_len above PAT_W stored as PAT_W
    cfg_write(4'b1011, 3'd7, 1'b0, 8'd0, 1'b1);
    send(1'b1, 1'b0); send(1'b0, 1'b0); send(1'b1, 1'b0); send(1'b1, 1'b1);
    do_abort();

    // Counter saturation with a one-bit pattern and overlap
    cfg_write(4'b0001, 3'd1, 1'b1, 8'd0, 1'b1);
    for (int i = 0; i < 256; i++) send(1'b1, 1'b1);
    chk("sat_cnt",  {24'd0, bus.match_cnt}, 32'd255);
    chk("sat_busy", {31'd0, bus.busy},      32'd1);
    do_abort();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
